// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multi-cycle MIPS core; optional MC_ILLEGAL_TRAP_EN traps unknown opcodes.
// Latency: lw 5, sw/R-type/ori 4, beq/j 3 cycles; outputs decode from the state register.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0, adding one cycle per stalled cycle.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       pc_source,
    output logic [2:0]       ALUop,
    output logic [3:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap
);

    localparam logic [3:0] S_INIT   = 4'd0;
    localparam logic [3:0] S_FETCH  = 4'd1;
    localparam logic [3:0] S_DECODE = 4'd2;
    localparam logic [3:0] S_MEMADR = 4'd3;
    localparam logic [3:0] S_MEMRD  = 4'd4;
    localparam logic [3:0] S_MEMWB  = 4'd5;
    localparam logic [3:0] S_MEMWR  = 4'd6;
    localparam logic [3:0] S_EXEC   = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;
    localparam logic [3:0] S_ORIEX  = 4'd10;
    localparam logic [3:0] S_ORIWB  = 4'd11;
    localparam logic [3:0] S_JUMP   = 4'd12;
`ifdef MC_ILLEGAL_TRAP_EN
    localparam logic [3:0] S_TRAP   = 4'd13;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0] state_r;
    logic [3:0] state_nxt;
    logic       known_op;

    // The branch decision itself is made in the datapath via pc_write_cond.
    logic unused_zero;
    assign unused_zero = zero;

    always_comb begin
        known_op = 1'b0;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI, OP_J: known_op = 1'b1;
            default:                                      known_op = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            S_INIT:   state_nxt = S_FETCH;
            S_FETCH:  state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_nxt = S_EXEC;
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_ORI:       state_nxt = S_ORIEX;
                    OP_J:         state_nxt = S_JUMP;
`ifdef MC_ILLEGAL_TRAP_EN
                    default:      state_nxt = S_TRAP;
`else
                    default:      state_nxt = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:  state_nxt = S_FETCH;
            S_MEMWR:  state_nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_nxt = S_ALUWB;
            S_ALUWB:  state_nxt = S_FETCH;
            S_BRANCH: state_nxt = S_FETCH;
            S_ORIEX:  state_nxt = S_ORIWB;
            S_ORIWB:  state_nxt = S_FETCH;
            S_JUMP:   state_nxt = S_FETCH;
`ifdef MC_ILLEGAL_TRAP_EN
            S_TRAP:   state_nxt = S_TRAP;
`endif
            default:  state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_INIT;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Outputs decode from state_r, so an async reset forces every strobe low at once.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_source     = 2'b00;
        ALUop         = 3'b000;
        retire        = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
`ifndef MC_ILLEGAL_TRAP_EN
                retire    = !known_op;
`endif
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                retire     = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                ALUop     = 3'b100;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                ALUop         = 3'b001;
                pc_source     = 2'b01;
                pc_write_cond = 1'b1;
                retire        = 1'b1;
            end
            S_ORIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                ALUop     = 3'b010;
            end
            S_ORIWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

`ifdef MC_ILLEGAL_TRAP_EN
    assign trap = (state_r == S_TRAP);
`else
    logic unused_known_op;
    assign unused_known_op = known_op;
    assign trap = 1'b0;
`endif

    assign state = state_r;

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle MIPS core.
- Sequences one shared ALU, a unified instruction/data memory and the register file across the FETCH, DECODE, EXEC, MEM and WB steps.
- Emits the 3-bit ALUop consumed by ALU_control: 000 add, 001 sub (beq), 010 or (ori), 100 R-type funct decode.
- Supports R-type, lw, sw, beq, ori and j. Memory accesses stall on a ready handshake.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  IR[31:26], valid from DECODE onward
- zero  in  1  ALU zero flag, used for beq
- mem_ready  in  1  memory completes the current read/write this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load when zero=1
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  destination register: 0 = rt, 1 = rd
- mem_to_reg  out  1  write-back source: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = A register
- alu_src_b  out  2  ALU B input: 00 = B, 01 = 4, 10 = extended imm, 11 = imm<<2
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- ALUop  out  3  to ALU_control
- state  out  4  current state code, for debug
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- instr_count  out  CNT_W  count of retired instructions
- trap  out  1  illegal-opcode indication (only with the feature enabled)

Behaviour:
- Moore FSM. The only Mealy terms are the mem_ready gating noted per state. Every output not listed for a state is 0.
- Reset (async, while rst_n=0):
  - state = INIT(0), instr_count = 0, all outputs 0.
  - An assertion mid-instruction aborts it immediately; no write strobe may survive into INIT.
- INIT(0): all outputs 0. Next state FETCH.
- FETCH(1):
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, ALUop=000, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE(2): alu_src_a=0, alu_src_b=11, ALUop=000 (precomputes the branch target). Next state by op:
  - 000000 -> EXEC
  - 100011 or 101011 -> MEMADR
  - 000100 -> BRANCH
  - 001101 -> ORIEX
  - 000010 -> JUMP
  - any other op -> FETCH with retire=1 (executed as a NOP)
- MEMADR(3): alu_src_a=1, alu_src_b=10, ALUop=000. op=100011 -> MEMRD, otherwise -> MEMWR.
- MEMRD(4): mem_read=1, i_or_d=1. Holds until mem_ready=1, then -> MEMWB.
- MEMWB(5): reg_dst=0, mem_to_reg=1, reg_write=1, retire=1. Next state FETCH.
- MEMWR(6): mem_write=1, i_or_d=1. Holds until mem_ready=1; retire = mem_ready; then -> FETCH.
- EXEC(7): alu_src_a=1, alu_src_b=00, ALUop=100. Next state ALUWB.
- ALUWB(8): reg_dst=1, reg_write=1, retire=1. Next state FETCH.
- BRANCH(9): alu_src_a=1, alu_src_b=00, ALUop=001, pc_source=01, pc_write_cond=1, retire=1. Next state FETCH.
- ORIEX(10): alu_src_a=1, alu_src_b=10, ALUop=010. The datapath zero-extends the immediate for ori. Next state ORIWB.
- ORIWB(11): reg_dst=0, reg_write=1, retire=1. Next state FETCH.
- JUMP(12): pc_source=10, pc_write=1, retire=1. Next state FETCH.
- Instruction latency with mem_ready held at 1: lw 5; sw, R-type and ori 4; beq and j 3 cycles. Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- instr_count increments by 1 on each retire and wraps from 2^CNT_W-1 to 0.
- mem_read and mem_write are never asserted in the same cycle.
- state output is the raw state register.

Optional Feature:
- Macro: MC_ILLEGAL_TRAP_EN.
- Defined:
  - An unknown op in DECODE goes to TRAP(13).
  - In TRAP, trap=1 and all other outputs are 0; there is no retire.
  - TRAP is held until reset.
- Undefined:
  - An unknown op is a NOP (DECODE -> FETCH with retire=1).
  - trap is tied to 0.
  - State code 13 is unused.

Test Plan:
- Reset release with mem_ready=1 -> INIT for 1 cycle, then FETCH. instr_count=0 and every write strobe 0 before the first FETCH edge.
- op=000000 with mem_ready=1 -> states 1,2,7,8. ALUop=100 in EXEC; reg_dst=1 and reg_write=1 in ALUWB; retire pulse; instr_count 0->1.
- op=100011 with mem_ready low for 3 cycles in MEMRD -> MEMRD lasts 4 cycles with i_or_d=1 and mem_read=1. Then MEMWB with mem_to_reg=1; total 8 cycles.
- op=000100 then op=001101 -> BRANCH has ALUop=001, pc_source=01, pc_write_cond=1. ORIEX has ALUop=010 and alu_src_b=10. instr_count advances by 2.
- rst_n asserted while in MEMWR with mem_write=1 -> mem_write drops asynchronously, state=0, instr_count=0.
- op=111111 -> with MC_ILLEGAL_TRAP_EN: state 13, trap=1, instr_count unchanged. Without the macro: returns to FETCH and instr_count increments.
